// File: rtl/multichannel_gain.sv
// Streaming per-channel Q-format gain stage between FIFOs, with frame-atomic
// gain updates and optional saturation plus a clip counter.
module multichannel_gain #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int OUT_SHIFT  = 4,
    parameter int CHANNELS   = 2,
    parameter bit SATURATE   = 1'b1,
    localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    input  logic                  gain_wr_en,
    input  logic [SEL_W-1:0]      gain_sel,
    input  logic [GAIN_WIDTH-1:0] gain_in,
    output logic [15:0]           clip_count
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH;
    localparam int SW = PW + OUT_SHIFT;
    localparam logic signed [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << FRAC_BITS;
    localparam logic signed [PW-1:0]         RND   = (PW'(1) << FRAC_BITS) - PW'(1);
    localparam logic [SEL_W-1:0]             LAST  = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {S_READ, S_MUL, S_SCALE, S_WRITE} state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  sample_q;
    logic signed [PW-1:0]          product_q, product_d;
    logic [DATA_WIDTH-1:0]         result_q, result_d;
    logic [15:0]                   clip_q;
    logic [SEL_W-1:0]              ch_idx_q;
    logic signed [GAIN_WIDTH-1:0]  shadow_q [CHANNELS];
    logic signed [GAIN_WIDTH-1:0]  active_q [CHANNELS];
    logic signed [PW-1:0]          biased;
    logic signed [SW-1:0]          scaled;
    logic                          ovf, clip;
    logic                          commit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_READ;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_READ:  if (!in_empty) state_d = S_MUL;
            S_MUL:   state_d = S_SCALE;
            S_SCALE: state_d = S_WRITE;
            S_WRITE: if (!out_full) state_d = S_READ;
            default: state_d = S_READ;
        endcase
    end

    always_comb begin
        in_rd_en  = (state_q == S_READ)  && !in_empty && !reset;
        out_wr_en = (state_q == S_WRITE) && !out_full && !reset;
        out_din   = result_q;
    end

    // Bias negative products so the arithmetic shift rounds toward zero; the
    // widened shift lets out-of-range detection see every bit above DATA_WIDTH.
    always_comb begin
        product_d = PW'(sample_q) * PW'(active_q[ch_idx_q]);
        biased    = product_q[PW-1] ? product_q + RND : product_q;
        scaled    = SW'(biased >>> FRAC_BITS) << OUT_SHIFT;
        ovf       = !((&scaled[SW-1:DATA_WIDTH-1]) || !(|scaled[SW-1:DATA_WIDTH-1]));
        clip      = 1'b0;
        result_d  = scaled[DATA_WIDTH-1:0];
        if (SATURATE && ovf) begin
            clip     = 1'b1;
            result_d = scaled[SW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    assign commit     = (state_q == S_READ) && (ch_idx_q == '0);
    assign clip_count = clip_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q  <= '0;
            product_q <= '0;
            result_q  <= '0;
            clip_q    <= '0;
            ch_idx_q  <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= UNITY;
                active_q[c] <= UNITY;
            end
        end else begin
            if (state_q == S_READ && !in_empty) sample_q <= in_dout;
            if (state_q == S_MUL) product_q <= product_d;
            if (state_q == S_SCALE) begin
                result_q <= result_d;
                if (clip && clip_q != '1) clip_q <= clip_q + 16'd1;
            end
            if (state_q == S_WRITE && !out_full)
                ch_idx_q <= (ch_idx_q == LAST) ? '0 : ch_idx_q + SEL_W'(1);
            // Active bank sees the shadow as it stood before this cycle's write.
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (commit) active_q[c] <= shadow_q[c];
                if (gain_wr_en && gain_sel == SEL_W'(c)) shadow_q[c] <= gain_in;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_gain.sv
// Directed bench for multichannel_gain: a saturating and a wrapping instance
// share all stimulus; expected values are hand-computed.
module tb_multichannel_gain;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_dout;
    logic        in_empty, out_full, gain_wr_en;
    logic [0:0]  gain_sel;
    logic [31:0] gain_in;
    logic        in_rd_en, out_wr_en, in_rd_en_ns, out_wr_en_ns;
    logic [31:0] out_din, out_din_ns;
    logic [15:0] clip_count, clip_count_ns;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    multichannel_gain #(
        .DATA_WIDTH(32), .GAIN_WIDTH(32), .FRAC_BITS(10),
        .OUT_SHIFT(4), .CHANNELS(2), .SATURATE(1'b1)
    ) u_sat (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out_din(out_din), .out_full(out_full),
        .out_wr_en(out_wr_en), .gain_wr_en(gain_wr_en), .gain_sel(gain_sel),
        .gain_in(gain_in), .clip_count(clip_count)
    );

    multichannel_gain #(
        .DATA_WIDTH(32), .GAIN_WIDTH(32), .FRAC_BITS(10),
        .OUT_SHIFT(4), .CHANNELS(2), .SATURATE(1'b0)
    ) u_wrap (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(in_rd_en_ns), .out_din(out_din_ns), .out_full(out_full),
        .out_wr_en(out_wr_en_ns), .gain_wr_en(gain_wr_en), .gain_sel(gain_sel),
        .gain_in(gain_in), .clip_count(clip_count_ns)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] g0;
        logic [31:0] exp_sat;
        logic [31:0] exp_wrap;
        logic [15:0] clip;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake never seen within budget", name);
    endtask

    task automatic write_gain(input logic sel, input logic [31:0] g);
        @(negedge clock);
        gain_wr_en = 1'b1;
        gain_sel   = sel;
        gain_in    = g;
        @(negedge clock);
        gain_wr_en = 1'b0;
    endtask

    // Offer one sample, then wait for its write; optionally write ch0/ch1 gains
    // while that sample is in S_MUL and S_SCALE.
    task automatic run_sample(input logic [31:0] din, input bit mid_gw, input logic [31:0] mid_g,
                              output logic [31:0] dout, output logic [31:0] dout_ns,
                              output int lat);
        int n;
        dout = 'x; dout_ns = 'x; lat = -1;
        @(negedge clock);
        in_dout  = din;
        in_empty = 1'b0;
        #1;
        n = 0;
        while (!in_rd_en && n < 20) begin
            @(negedge clock); #1; n++;
        end
        if (!in_rd_en) begin
            in_empty = 1'b1;
            timeout("pop");
            return;
        end
        @(negedge clock);
        in_empty = 1'b1;
        lat = 1;
        if (mid_gw) begin
            gain_wr_en = 1'b1; gain_sel = 1'b0; gain_in = mid_g;
        end
        #1;
        n = 0;
        while (!out_wr_en && n < 20) begin
            @(negedge clock);
            if (mid_gw) begin
                if (lat == 1) gain_sel = 1'b1;
                else          gain_wr_en = 1'b0;
            end
            #1; lat++; n++;
        end
        gain_wr_en = 1'b0;
        if (!out_wr_en) begin
            timeout("write");
            return;
        end
        dout    = out_din;
        dout_ns = out_din_ns;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, dn;
        int lat;
        int cyc, ip, op, first_pop, last_wr, bad_bp;

        vt[0] = '{32'd100,        32'd1024, 32'd1600,     32'd1600,     16'd0};
        vt[1] = '{32'hFFFFFF9C,   32'd1024, 32'hFFFFF9C0, 32'hFFFFF9C0, 16'd0};
        vt[2] = '{32'hFFFFFFFD,   32'd512,  32'hFFFFFFF0, 32'hFFFFFFF0, 16'd0};
        vt[3] = '{32'd7,          32'd1024, 32'd112,      32'd112,      16'd0};
        vt[4] = '{32'd3,          32'd512,  32'd16,       32'd16,       16'd0};
        vt[5] = '{32'd0,          32'd1024, 32'd0,        32'd0,        16'd0};
        vt[6] = '{32'h10000000,   32'd1024, 32'h7FFFFFFF, 32'h00000000, 16'd1};
        vt[7] = '{32'hF0000000,   32'd1024, 32'h80000000, 32'h00000000, 16'd2};
        vt[8] = '{32'h07FFFFFF,   32'd1024, 32'h7FFFFFF0, 32'h7FFFFFF0, 16'd2};
        vt[9] = '{32'hF8000000,   32'd1024, 32'h80000000, 32'h80000000, 16'd2};

        reset = 1'b1; in_empty = 1'b0; in_dout = 32'd5; out_full = 1'b0;
        gain_wr_en = 1'b0; gain_sel = 1'b0; gain_in = '0;
        #12;
        check("rst_rd_en",  in_rd_en,   0);
        check("rst_wr_en",  out_wr_en,  0);
        check("rst_out",    out_din,    0);
        check("rst_clip",   clip_count, 0);
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b1;

        // Even entries are channel 0 and reload the ch0 gain first; ch1 stays unity.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) write_gain(1'b0, vt[i].g0);
            run_sample(vt[i].din, 1'b0, '0, d, dn, lat);
            check($sformatf("vec%0d_out", i),       d,             vt[i].exp_sat);
            check($sformatf("vec%0d_wrap_out", i),  dn,            vt[i].exp_wrap);
            check($sformatf("vec%0d_latency", i),   lat,           3);
            check($sformatf("vec%0d_clip", i),      clip_count,    {16'd0, vt[i].clip});
            check($sformatf("vec%0d_wrap_clip", i), clip_count_ns, 0);
        end

        // Gain writes during an in-flight ch1 sample take effect from the next frame.
        run_sample(32'd10, 1'b0, '0, d, dn, lat);
        check("frame_ch0_old", d, 32'd160);
        run_sample(32'd10, 1'b1, 32'd2048, d, dn, lat);
        check("frame_ch1_inflight", d, 32'd160);
        run_sample(32'd10, 1'b0, '0, d, dn, lat);
        check("frame_ch0_new", d, 32'd320);
        run_sample(32'd10, 1'b0, '0, d, dn, lat);
        check("frame_ch1_new", d, 32'd320);

        // Eight back-to-back samples, output stalled for 10 cycles on the first.
        ip = 0; op = 0; first_pop = -1; last_wr = 0; bad_bp = 0; cyc = 0;
        while (cyc < 200 && op < 8) begin
            @(negedge clock);
            in_empty = (ip >= 8);
            in_dout  = 32'(ip + 1);
            out_full = (first_pop >= 0 && cyc >= first_pop + 3 && cyc < first_pop + 13);
            #1;
            if (out_full && (out_wr_en || in_rd_en)) bad_bp++;
            if (in_rd_en) begin
                if (first_pop < 0) first_pop = cyc;
                ip++;
            end
            if (out_wr_en) begin
                check($sformatf("bp_data%0d", op), out_din, 32'((op + 1) * 32));
                op++;
                last_wr = cyc;
            end
            cyc++;
        end
        in_empty = 1'b1; out_full = 1'b0;
        check("bp_stall_quiet", bad_bp, 0);
        check("bp_count", op, 8);
        check("bp_span", last_wr - first_pop, 41);

        // Reset while a sample sits in S_SCALE.
        @(negedge clock);
        in_dout = 32'd10; in_empty = 1'b0;
        #1;
        if (!in_rd_en) timeout("rst_pop");
        @(negedge clock);
        in_empty = 1'b1;
        @(negedge clock);
        reset = 1'b1; in_empty = 1'b0;
        #1;
        check("midrst_out",      out_din,    0);
        check("midrst_wrap_out", out_din_ns, 0);
        check("midrst_wr_en",    out_wr_en,  0);
        check("midrst_rd_en",    in_rd_en,   0);
        check("midrst_clip",     clip_count, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b1;
        write_gain(1'b0, 32'd3072);
        run_sample(32'd10, 1'b0, '0, d, dn, lat);
        check("postrst_ch0", d, 32'd480);
        run_sample(32'd10, 1'b0, '0, d, dn, lat);
        check("postrst_ch1_unity", d, 32'd160);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multichannel_gain.md
# multichannel_gain

Streaming, multi-channel fixed-point gain stage for the FM receiver audio path. It applies a per-channel Q-format gain to interleaved samples: channel 0, 1, …, CHANNELS-1, then repeating. It sits between FIFOs, for example after de-emphasis and before the audio output FIFO. It generalises the fixed combinational gain to configurable width, fraction bits, output shift and channel count. It adds a FIFO handshake, frame-atomic gain updates and optional saturation with a clip counter.

## Interface
- DATA_WIDTH, 32, signed sample width in and out
- GAIN_WIDTH, 32, signed gain width; gain is Q(GAIN_WIDTH-FRAC_BITS).FRAC_BITS
- FRAC_BITS, 10, fractional bits removed after the multiply
- OUT_SHIFT, 4, left shift applied after dequantisation
- CHANNELS, 2, number of interleaved channels (≥1)
- SATURATE, 1, 1 = clamp to DATA_WIDTH range; 0 = keep low DATA_WIDTH bits
- clock  in  1  sole clock; all state on its rising edge
- reset  in  1  asynchronous, active-high
- in_dout  in  DATA_WIDTH  input FIFO head, first-word-fall-through
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  pop input FIFO
- out_din  out  DATA_WIDTH  result to output FIFO
- out_full  in  1  output FIFO full
- out_wr_en  out  1  push output FIFO
- gain_wr_en  in  1  write gain_in into shadow gain of gain_sel
- gain_sel  in  max(1,clog2(CHANNELS))  channel select; values ≥CHANNELS ignored
- gain_in  in  GAIN_WIDTH  new signed Q gain
- clip_count  out  16  saturating count of clamped samples

## Operation
- FSM states are S_READ → S_MUL → S_SCALE → S_WRITE → S_READ.
- S_READ: if !in_empty, assert in_rd_en, latch in_dout into sample_r, go to S_MUL. Otherwise stay.
- S_MUL: product_r = sample_r × active_gain[ch_idx], full DATA_WIDTH+GAIN_WIDTH signed.
- S_SCALE:
  - Dequantise with round toward zero: if product negative, add 2^FRAC_BITS−1, then arithmetic shift right by FRAC_BITS.
  - Shift left by OUT_SHIFT in full width.
  - If SATURATE, clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. Increment clip_count, stopping at 0xFFFF, when a clamp occurs.
  - If SATURATE=0, truncate to the low DATA_WIDTH bits; clip_count stays 0.
  - Register the result into result_r.
- S_WRITE: if !out_full, assert out_wr_en with out_din=result_r, advance ch_idx (wraps CHANNELS−1→0), go to S_READ. Otherwise hold.
- in_rd_en = (state==S_READ && !in_empty && !reset). out_wr_en = (state==S_WRITE && !out_full && !reset). out_din = result_r.
- Gain update:
  - A write goes to the shadow bank only.
  - Shadow copies into the active bank in every cycle with state==S_READ && ch_idx==0, so one frame always uses one gain set.
  - A write in a commit cycle lands in shadow and is committed at the next such cycle.
- Reset values:
  - State S_READ, ch_idx 0.
  - sample_r, product_r, result_r and clip_count all 0.
  - Every shadow and active gain is 1<<FRAC_BITS, i.e. unity.
  - in_rd_en and out_wr_en are 0 while reset is high.

## Timing
- Pop in cycle T; the product registers at end of T+1; the result registers at end of T+2; out_wr_en is asserted at T+3 at the earliest.
- Throughput is one sample per 4 cycles with no backpressure. Each cycle of out_full adds one cycle.
- No input is popped while a result is pending; there is no internal buffering beyond one sample.
- in_empty and out_full are sampled in the same cycle the enable is driven; the FIFOs must honour same-cycle enables.
- Reset mid-sample drops the sample in flight; no partial write occurs. After release the next pop is channel 0.
- in_empty toggling mid-frame stalls in S_READ without changing ch_idx; channel alignment is preserved.

## Test plan
- Unity pass: defaults, CHANNELS=2, inputs 100 then −100 → outputs 1600, −1600 (×16). Each out_wr_en comes 3 cycles after its in_rd_en. clip_count=0.
- Round-to-zero: gain ch0=512 (0.5), din=−3 → product −1536 → −1 → out −16. With din=3 → out 16.
- Saturation, SATURATE=1, gain 1024:
  - din=2^28 → 0x7FFFFFFF, clip_count=1.
  - din=−2^28 → 0x80000000, clip_count=2.
  - With SATURATE=0 the same inputs give 0x00000000 and clip_count=0.
- Frame-atomic update:
  - Write gain ch0=2048 and ch1=2048 while ch_idx=1 is in S_MUL. The in-flight ch1 output still uses 1024.
  - The next ch0/ch1 outputs for din=10 are 320 each.
- Backpressure: hold out_full=1 for 10 cycles in S_WRITE → out_wr_en=0 and in_rd_en=0 throughout. Exactly one write follows release, and there is no sample loss across 8 samples.
- Reset mid-operation: assert reset in S_SCALE → outputs go 0 immediately and gains return to unity. The next input is processed as channel 0.
